// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the external 64-bit MAC datapath.
//
// A job is a dot product of `len` operand pairs. The controller:
//   1. clears the MAC for one cycle (CLR),
//   2. streams operand pairs under a valid/ready handshake (RUN),
//   3. waits out the MAC pipeline (DRAIN, MAC_LAT+1 cycles),
//   4. presents the captured accumulator on a result handshake (DONE).
// A zero-length job skips the MAC entirely and returns 0.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   start, len        job request and pair count, sampled in IDLE only
//   busy              high in every state except IDLE
//   in_valid/in_ready operand-pair handshake; in_x/in_y operands
//   mac_clr           one-cycle synchronous clear to the MAC
//   mac_x/mac_y       operands to the MAC, zero unless a beat occurs
//   mac_acc           MAC accumulator output
//   res_valid/ready   result handshake; res_data captured dot product
//   res_ovf           (only with MAC_SEQ_OVF_DET_EN) accumulator wrapped
//
// Optional feature macro: MAC_SEQ_OVF_DET_EN adds wrap detection and the
// res_ovf port. Without it there is no port, comparator or extra state.
module mac_seq_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 64,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_x,
  input  logic [DW-1:0]    in_y,
  output logic             mac_clr,
  output logic [DW-1:0]    mac_x,
  output logic [DW-1:0]    mac_y,
  input  logic [AW-1:0]    mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_data
`ifdef MAC_SEQ_OVF_DET_EN
  ,
  output logic             res_ovf
`endif
);

  // Drain counter only needs to reach MAC_LAT; one spare bit keeps the
  // width sane for MAC_LAT=1.
  localparam int DCW = $clog2(MAC_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [DCW-1:0]   dcnt;
  logic             beat;

  // in_ready is only ever high in RUN, so a beat implies RUN.
  assign beat = in_valid & in_ready;

  // Zero-gating: the MAC has no enable, so feeding zeros makes it add 0
  // and hold its value during bubbles, drain and idle.
  assign mac_x = beat ? in_x : '0;
  assign mac_y = beat ? in_y : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              len_q   <= len;
              mac_clr <= 1'b1;
              state   <= CLR;
            end else begin
              // Empty job: answer 0 without touching the MAC.
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        CLR: begin
          mac_clr  <= 1'b0;
          cnt      <= '0;
          in_ready <= 1'b1;
          state    <= RUN;
        end

        RUN: begin
          if (beat) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              in_ready <= 1'b0;
              dcnt     <= '0;
              state    <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // MAC_LAT cycles through the MAC input register, +1 through the
          // accumulator register, then mac_acc holds the full sum.
          if (dcnt == DCW'(MAC_LAT)) begin
            res_data  <= mac_acc;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          mac_clr   <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_OVF_DET_EN
  // Unsigned accumulation only ever grows; a decrease means it wrapped.
  logic [AW-1:0] prev_acc;
  logic          ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_acc <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length job never passes CLR, so drop a stale flag here.
          if (start && len == '0) ovf_q <= 1'b0;
        end
        CLR: begin
          // mac_acc still shows the old job here; the MAC is 0 from RUN on.
          prev_acc <= '0;
          ovf_q    <= 1'b0;
        end
        RUN, DRAIN: begin
          prev_acc <= mac_acc;
          if (mac_acc < prev_acc) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_ovf = res_valid & ovf_q;
`endif

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the 64-bit MAC datapath. Accepts a dot-product job of `len` operand pairs and clears the MAC. It then streams operand pairs into the MAC under a valid/ready handshake and waits out the MAC pipeline latency. Finally it captures the accumulator and presents it on a result handshake. Sits between an operand source (memory reader/DMA) and the MAC instance; the MAC itself is external.

Parameters:
DW, 32, operand width of x/y.
AW, 64, accumulator width (must be 2*DW).
LEN_W, 8, width of job length field; max job = 2^LEN_W-1 pairs.
MAC_LAT, 1, cycles from last mac_en pair to that product appearing on mac_acc (>=1).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  job request, sampled in IDLE only
len  input  LEN_W  number of operand pairs, sampled with start
busy  output  1  high in every state except IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  controller accepts pair
in_x  input  DW  operand x
in_y  input  DW  operand y
mac_clr  output  1  synchronous clear to MAC accumulator/input regs
mac_x  output  DW  operand to MAC
mac_y  output  DW  operand to MAC
mac_acc  input  AW  MAC accumulator output
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  AW  captured dot product

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, in_ready, mac_clr, res_valid = 0; res_data = 0; mac_x/mac_y = 0; all counters 0.
- FSM states are IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - start=1, len!=0: latch len, go to CLR.
  - start=1, len==0: res_data<=0, go directly to DONE. The MAC is untouched.
  - start=0: stay in IDLE.
- CLR: mac_clr=1 for exactly one cycle, pair counter<=0, go to RUN.
- RUN:
  - in_ready=1.
  - On in_valid&&in_ready (a "beat"): mac_x=in_x, mac_y=in_y combinationally in that cycle, and the counter increments.
  - Without a beat, mac_x=mac_y=0. This zero-gating means the enable-less MAC adds 0 and holds its value.
  - On the beat where counter==len-1, go to DRAIN with drain counter<=0. in_ready=0 from the next cycle.
- DRAIN:
  - in_ready=0, operands forced 0.
  - Wait MAC_LAT+1 cycles: MAC_LAT for the input register, +1 for the accumulator register.
  - On the final drain cycle, res_data<=mac_acc and go to DONE.
- DONE:
  - res_valid=1. res_data is held stable while res_valid=1 && res_ready=0.
  - On res_valid&&res_ready, go to IDLE; res_valid=0 next cycle.
- start while busy=1 is ignored (no queueing, no error).
- Result latency with back-to-back beats and res_ready=1 is len + MAC_LAT + 3 cycles from the start cycle to res_valid.
- Width rule: products are unsigned DW x DW -> AW. The sum wraps modulo 2^AW and no saturation is applied.
- Reset mid-job aborts immediately; no partial result is emitted. The MAC is re-cleared by the next job's CLR.
- len is captured at start; changes to len during a job have no effect.

Optional Feature:
Macro MAC_SEQ_OVF_DET_EN.
- When defined:
  - Adds output res_ovf (1 bit, reset 0).
  - During DRAIN and RUN, the controller keeps a registered copy of the previous mac_acc value.
  - It sets a sticky overflow flag if the new mac_acc < the previous value, which only happens on unsigned wrap.
  - The flag is cleared in CLR and presented as res_ovf alongside res_valid.
- When undefined: no port, no comparator, no extra registers; behaviour is otherwise identical.

Test Plan:
- Basic dot product: rst low 2 cycles then high; start, len=3; pairs (5,1),(5,2),(5,3) back-to-back, res_ready=1 -> res_valid after len+MAC_LAT+3 cycles, res_data=30, busy drops the cycle after handshake.
- Input bubbles: len=4, pairs (2,3),(4,4),(1,7),(10,10) with in_valid low 2 cycles between each -> res_data=129; mac_x/mac_y=0 during bubbles.
- Zero length plus output backpressure:
  - start, len=0 -> res_valid=1 next cycle, res_data=0, mac_clr never asserted.
  - Then a new job with len=2, pairs (3,3),(4,4), res_ready held 0 for 5 cycles -> res_data=25 stable all 5 cycles, accepted on 6th.
- Start while busy: start pulsed during RUN and DONE with len=9 -> ignored; the original job (len=2, pairs (6,7),(1,1)) gives 43.
- Reset mid-job: len=5, 2 beats, assert rst -> all outputs 0 immediately. Then a new job len=1, pair (8,8) -> res_data=64 (no stale accumulation).
- (MAC_SEQ_OVF_DET_EN) len=2, pairs (0xFFFFFFFF,0xFFFFFFFF) twice -> res_data=0xFFFFFFFC_00000002 wrapped, res_ovf=1. The next job len=1 pair (1,1) -> res_ovf=0.
